// File: rtl/comb_logic_preimage_solver_pkg.sv
// comb_solver_pkg: shared state encoding, candidate bound and golden F lookup
// for the preimage solver and anything that needs to check it.
package comb_solver_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;
    localparam logic [3:0] CAND_LAST = 4'd15;
    // Entry k holds F(k) as {x,y,z}; entry 15 sits in the top bits.
    localparam logic [47:0] F_TABLE = {3'b000, 3'b000, 3'b000, 3'b111,
                                       3'b001, 3'b010, 3'b010, 3'b101,
                                       3'b001, 3'b010, 3'b010, 3'b101,
                                       3'b001, 3'b110, 3'b110, 3'b100};
    function automatic logic [2:0] f_xyz(input logic [3:0] abcd);
        return F_TABLE[abcd*3 +: 3];
    endfunction
endpackage

// File: rtl/comb_logic_preimage_solver_if.sv
// comb_logic_preimage_solver_if: target/solution/done handshake bundle; the
// solver uses the slave view, its driver uses the master view.
interface comb_logic_preimage_solver_if #(parameter int CNT_W = 5);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [2:0]       tgt_xyz;
    logic             sol_valid;
    logic             sol_ready;
    logic [3:0]       sol_abcd;
    logic             done_valid;
    logic [CNT_W-1:0] done_count;
    logic             done_none;
    logic             busy;
    modport slave (input tgt_valid, tgt_xyz, sol_ready,
                   output tgt_ready, sol_valid, sol_abcd, done_valid, done_count, done_none, busy);
    modport master (output tgt_valid, tgt_xyz, sol_ready,
                    input tgt_ready, sol_valid, sol_abcd, done_valid, done_count, done_none, busy);
endinterface

// File: rtl/comb_logic_preimage_solver_xyz_eval.sv
// comb_xyz_eval: gate-level 4-in/3-out function F, {a,b,c,d} -> {x,y,z}.
module comb_xyz_eval (
    input  logic [3:0] abcd,
    output logic [2:0] xyz
);
    logic a, b, c, d, ab;
    assign {a, b, c, d} = abcd;
    assign ab = a & b;
    assign xyz[2] = (~a & ~b & ~(c & d)) | ((a | b) & ~c & ~d);
    assign xyz[1] = (ab ~^ (c ~^ d)) & (ab ^ (c | d));
    assign xyz[0] = (ab | ~(c & d)) ^ (~(a | b) | c | d);
endmodule

// File: rtl/comb_logic_preimage_solver.sv
// comb_logic_preimage_solver: scans candidates 0..15 through F, streams every
// {a,b,c,d} that hits the latched target, then pulses a done summary.
module comb_logic_preimage_solver
    import comb_solver_pkg::*;
#(
    parameter bit FIRST_ONLY = 1'b0,
    parameter int CNT_W      = 5
) (
    input logic clk,
    input logic rst,
    comb_logic_preimage_solver_if.slave io
);
    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f_idx;

    comb_xyz_eval u_eval (.abcd(idx_q), .xyz(f_idx));

    // The idx==15 exits come before any increment, so idx never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (io.tgt_valid) begin
                tgt_d   = io.tgt_xyz;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = EVAL;
            end
            EVAL: if (f_idx == tgt_q) state_d = EMIT;
                  else if (idx_q == CAND_LAST) state_d = DONE;
                  else idx_d = idx_q + 4'd1;
            EMIT: if (io.sol_ready) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (idx_q == CAND_LAST || FIRST_ONLY) state_d = DONE;
                else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = EVAL;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Summary outputs are gated so everything reads 0 outside its own state.
    assign io.tgt_ready  = state_q == IDLE;
    assign io.busy       = state_q != IDLE;
    assign io.sol_valid  = state_q == EMIT;
    assign io.sol_abcd   = io.sol_valid ? idx_q : '0;
    assign io.done_valid = state_q == DONE;
    assign io.done_count = io.done_valid ? cnt_q : '0;
    assign io.done_none  = io.done_valid && cnt_q == '0;
endmodule
